clint_axi_dp: RTL and testbench

Core-local interruptor (CLINT) slave on the core's cacheless peripheral AXI port (the DP port). Owns the machine timer (`mtime`), timer compare (`mtimecmp`) and software-interrupt (`msip`) registers. Its outputs drive the core's `rdtime` input and its machine timer and software interrupt inputs, replacing the free-running tick counter and the constant-zero interrupt tie-offs.

---
 rtl/clint_axi_dp.sv | 215 +++++++++++++++++++++
 tb/tb_clint_axi_dp.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_axi_dp.sv
// CLINT slave on the core's peripheral AXI port: owns mtime, mtimecmp and msip,
// and produces the machine timer/software interrupt levels plus the rdtime value.
module clint_axi_dp #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int          TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_awaddr,
   input  logic [2:0]  s_awsize,
   input  logic [3:0]  s_awcache,
   input  logic [2:0]  s_awprot,
   input  logic        s_wvalid,
   output logic        s_wready,
   input  logic [63:0] s_wdata,
   input  logic [7:0]  s_wstrb,
   input  logic        s_wlast,
   output logic        s_bvalid,
   input  logic        s_bready,
   output logic [1:0]  s_bresp,
   input  logic        s_arvalid,
   output logic        s_arready,
   input  logic [31:0] s_araddr,
   input  logic [2:0]  s_arsize,
   input  logic [3:0]  s_arcache,
   input  logic [2:0]  s_arprot,
   output logic        s_rvalid,
   input  logic        s_rready,
   output logic [63:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rlast,
   output logic [63:0] mtime,
   output logic        int_m_timer,
   output logic        int_m_software
);

   localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
   typedef enum logic { R_IDLE = 1'b0, R_RESP = 1'b1 } r_state_e;
   typedef enum logic [1:0] { SEL_NONE = 2'd0, SEL_MSIP = 2'd1, SEL_CMP = 2'd2, SEL_TIME = 2'd3 } sel_e;

   function automatic sel_e decode(input logic [31:0] addr);
      sel_e sel;
      sel = SEL_NONE;
      if (addr[31:16] == BASE_ADDR[31:16]) begin
         case (addr[15:3])
            13'h0000: sel = SEL_MSIP;
            13'h0800: sel = SEL_CMP;
            13'h17FF: sel = SEL_TIME;
            default:  sel = SEL_NONE;
         endcase
      end else begin
         sel = SEL_NONE;
      end
      return sel;
   endfunction

   function automatic logic [63:0] merge_bytes(input logic [63:0] old_v, input logic [63:0] new_v,
                                               input logic [7:0] strb);
      logic [63:0] res;
      res = old_v;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_v[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_v[8*b +: 8];
         end
      end
      return res;
   endfunction

   w_state_e      w_state_q, w_state_d;
   r_state_e      r_state_q, r_state_d;
   logic [1:0]    bresp_q, bresp_d;
   logic [1:0]    rresp_q, rresp_d;
   logic [63:0]   rdata_q, rdata_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          msip_q, msip_d;
   logic          timer_irq_q, timer_irq_d;
   logic          w_fire, r_fire, tick;
   logic [63:0]   mtime_inc;
   sel_e          wsel, rsel;
   logic          unused_ok;

   assign unused_ok = ^{s_awsize, s_awcache, s_awprot, s_arsize, s_arcache, s_arprot,
                        s_wlast, s_awaddr[2:0], s_araddr[2:0]};

   assign wsel      = decode(s_awaddr);
   assign rsel      = decode(s_araddr);
   assign w_fire    = (w_state_q == W_IDLE) & s_awvalid & s_wvalid;
   assign r_fire    = (r_state_q == R_IDLE) & s_arvalid;
   assign s_awready = w_fire;
   assign s_wready  = w_fire;
   assign s_arready = r_fire;

   // Write channel: accept AW and W together only, then hold the response until bready.
   always_comb begin
      w_state_d = w_state_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: begin
            if (w_fire) begin
               w_state_d = W_RESP;
               bresp_d   = (wsel == SEL_NONE) ? 2'b11 : 2'b00;
            end else begin
               w_state_d = W_IDLE;
            end
         end
         W_RESP: begin
            if (s_bready) begin
               w_state_d = W_IDLE;
            end else begin
               w_state_d = W_RESP;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read channel: data is captured from the pre-write register state at accept.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (r_fire) begin
               r_state_d = R_RESP;
               rresp_d   = (rsel == SEL_NONE) ? 2'b11 : 2'b00;
               case (rsel)
                  SEL_MSIP: rdata_d = {63'd0, msip_q};
                  SEL_CMP:  rdata_d = mtimecmp_q;
                  SEL_TIME: rdata_d = mtime_q;
                  default:  rdata_d = 64'd0;
               endcase
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_RESP: begin
            if (s_rready) begin
               r_state_d = R_IDLE;
            end else begin
               r_state_d = R_RESP;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Timer and register updates; a same-cycle mtime write overrides only its strobed bytes.
   always_comb begin
      tick        = (presc_q == PRESC_MAX);
      presc_d     = tick ? '0 : presc_q + 1'b1;
      mtime_inc   = mtime_q + {63'd0, tick};
      mtime_d     = mtime_inc;
      mtimecmp_d  = mtimecmp_q;
      msip_d      = msip_q;
      timer_irq_d = (mtime_q >= mtimecmp_q);
      if (w_fire) begin
         case (wsel)
            SEL_MSIP: msip_d     = s_wstrb[0] ? s_wdata[0] : msip_q;
            SEL_CMP:  mtimecmp_d = merge_bytes(mtimecmp_q, s_wdata, s_wstrb);
            SEL_TIME: mtime_d    = merge_bytes(mtime_inc, s_wdata, s_wstrb);
            default:  mtime_d    = mtime_inc;
         endcase
      end else begin
         mtime_d = mtime_inc;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_state_q   <= W_IDLE;
         r_state_q   <= R_IDLE;
         bresp_q     <= 2'b00;
         rresp_q     <= 2'b00;
         rdata_q     <= 64'd0;
         presc_q     <= '0;
         mtime_q     <= 64'd0;
         mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip_q      <= 1'b0;
         timer_irq_q <= 1'b0;
      end else begin
         w_state_q   <= w_state_d;
         r_state_q   <= r_state_d;
         bresp_q     <= bresp_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
         presc_q     <= presc_d;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         msip_q      <= msip_d;
         timer_irq_q <= timer_irq_d;
      end
   end

   assign s_bvalid       = (w_state_q == W_RESP);
   assign s_bresp        = bresp_q;
   assign s_rvalid       = (r_state_q == R_RESP);
   assign s_rlast        = (r_state_q == R_RESP);
   assign s_rdata        = rdata_q;
   assign s_rresp        = rresp_q;
   assign mtime          = mtime_q;
   assign int_m_timer    = timer_irq_q;
   assign int_m_software = msip_q;

endmodule

// File: tb/tb_clint_axi_dp.sv
// Randomized bench for clint_axi_dp: a cycle-level reference model of the CLINT
// register file predicts every mtime/interrupt value and every AXI response.
module tb_clint_axi_dp;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
   logic [31:0] s_awaddr, s_araddr;
   logic [2:0]  s_awsize, s_awprot, s_arsize, s_arprot;
   logic [3:0]  s_awcache, s_arcache;
   logic [63:0] s_wdata, s_rdata, dut_mtime;
   logic [7:0]  s_wstrb;
   logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [1:0]  s_bresp, s_rresp;
   logic        int_m_timer, int_m_software;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [63:0] m_mtime, m_cmp;
   logic        m_msip, m_irq;
   int          m_presc;

   logic [31:0] addr_tab [7] = '{32'h0200_0000, 32'h0200_4000, 32'h0200_BFF8, 32'h0200_1000,
                                 32'h0300_4000, 32'h0200_4004, 32'h0200_BFFC};

   clint_axi_dp #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
      .s_awcache(s_awcache), .s_awprot(s_awprot),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arsize(s_arsize),
      .s_arcache(s_arcache), .s_arprot(s_arprot),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .mtime(dut_mtime), .int_m_timer(int_m_timer), .int_m_software(int_m_software)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // 0 = unmapped, 1 = msip, 2 = mtimecmp, 3 = mtime
   function automatic int region(input logic [31:0] a);
      logic [15:0] off;
      off = {a[15:3], 3'b000};
      if (a[31:16] != 16'h0200) return 0;
      if (off == 16'h0000) return 1;
      if (off == 16'h4000) return 2;
      if (off == 16'hBFF8) return 3;
      return 0;
   endfunction

   function automatic logic [1:0] resp_of(input logic [31:0] a);
      return (region(a) == 0) ? 2'b11 : 2'b00;
   endfunction

   function automatic logic [63:0] m_read(input logic [31:0] a);
      case (region(a))
         1: return {63'd0, m_msip};
         2: return m_cmp;
         3: return m_mtime;
         default: return 64'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_mtime = 64'd0;
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip  = 1'b0;
      m_irq   = 1'b0;
      m_presc = 0;
   endtask

   // one clock edge of the model; wr says a write was accepted at this edge
   task automatic model_advance(input bit wr);
      logic        irq_next;
      logic [63:0] t;
      irq_next = (m_mtime >= m_cmp);
      t = m_mtime;
      if (m_presc == TD - 1) begin
         t = m_mtime + 64'd1;
         m_presc = 0;
      end else begin
         m_presc = m_presc + 1;
      end
      if (wr) begin
         case (region(s_awaddr))
            1: if (s_wstrb[0]) m_msip = s_wdata[0];
            2: for (int b = 0; b < 8; b++) if (s_wstrb[b]) m_cmp[8*b +: 8] = s_wdata[8*b +: 8];
            3: for (int b = 0; b < 8; b++) if (s_wstrb[b]) t[8*b +: 8] = s_wdata[8*b +: 8];
            default: ;
         endcase
      end
      m_mtime = t;
      m_irq   = irq_next;
   endtask

   task automatic step(input bit wr);
      @(posedge clk);
      model_advance(wr);
      #1;
      check_eq("mtime", dut_mtime, m_mtime);
      check_eq("int_m_timer", {63'd0, int_m_timer}, {63'd0, m_irq});
      check_eq("int_m_software", {63'd0, int_m_software}, {63'd0, m_msip});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] st,
                            input int bdly, output logic [1:0] resp);
      logic [1:0] er;
      er = resp_of(a);
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = a; s_wdata = d; s_wstrb = st;
      #1;
      check_eq("awready", {63'd0, s_awready}, 64'd1);
      check_eq("wready", {63'd0, s_wready}, 64'd1);
      step(1'b1);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      resp = s_bresp;
      check_eq("bvalid", {63'd0, s_bvalid}, 64'd1);
      check_eq("bresp", {62'd0, s_bresp}, {62'd0, er});
      for (int k = 0; k < bdly; k++) begin
         step(1'b0);
         check_eq("bvalid_hold", {63'd0, s_bvalid}, 64'd1);
         check_eq("bresp_hold", {62'd0, s_bresp}, {62'd0, er});
      end
      s_bready = 1'b1;
      step(1'b0);
      s_bready = 1'b0;
      check_eq("bvalid_clr", {63'd0, s_bvalid}, 64'd0);
   endtask

   task automatic axi_read(input logic [31:0] a, input int rdly,
                           output logic [63:0] data, output logic [1:0] resp);
      logic [63:0] exp_d;
      logic [1:0]  er;
      exp_d = m_read(a);
      er = resp_of(a);
      s_arvalid = 1'b1; s_araddr = a;
      #1;
      check_eq("arready", {63'd0, s_arready}, 64'd1);
      step(1'b0);
      s_arvalid = 1'b0;
      data = s_rdata; resp = s_rresp;
      check_eq("rvalid", {63'd0, s_rvalid}, 64'd1);
      check_eq("rlast", {63'd0, s_rlast}, 64'd1);
      check_eq("rdata", s_rdata, exp_d);
      check_eq("rresp", {62'd0, s_rresp}, {62'd0, er});
      for (int k = 0; k < rdly; k++) begin
         step(1'b0);
         check_eq("rvalid_hold", {63'd0, s_rvalid}, 64'd1);
         check_eq("rdata_hold", s_rdata, exp_d);
      end
      s_rready = 1'b1;
      step(1'b0);
      s_rready = 1'b0;
      check_eq("rvalid_clr", {63'd0, s_rvalid}, 64'd0);
   endtask

   // concurrent write + read, then stall both responses while new requests wait
   task automatic axi_rw(input logic [31:0] wa, input logic [63:0] wd, input logic [7:0] ws,
                         input logic [31:0] ra, input int hold, output logic [63:0] rd);
      logic [63:0] exp_d;
      logic [1:0]  ewr, err;
      exp_d = m_read(ra); ewr = resp_of(wa); err = resp_of(ra);
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      s_awaddr = wa; s_wdata = wd; s_wstrb = ws; s_araddr = ra;
      #1;
      check_eq("rw_accept", {61'd0, s_awready, s_wready, s_arready}, 64'd7);
      step(1'b1);
      rd = s_rdata;
      s_awaddr = 32'h0200_BFF8; s_wdata = {$urandom, $urandom}; s_araddr = 32'h0200_4000;
      #1;
      for (int k = 0; k <= hold; k++) begin
         if (k > 0) step(1'b0);
         check_eq("rw_blocked", {61'd0, s_awready, s_wready, s_arready}, 64'd0);
         check_eq("rw_valids", {62'd0, s_bvalid, s_rvalid}, 64'd3);
         check_eq("rw_bresp", {62'd0, s_bresp}, {62'd0, ewr});
         check_eq("rw_rresp", {62'd0, s_rresp}, {62'd0, err});
         check_eq("rw_rdata", s_rdata, exp_d);
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      s_bready = 1'b1; s_rready = 1'b1;
      step(1'b0);
      s_bready = 1'b0; s_rready = 1'b0;
      check_eq("rw_done", {62'd0, s_bvalid, s_rvalid}, 64'd0);
   endtask

   initial begin
      logic [63:0] rd, old_cmp;
      logic [1:0]  rr;
      int          guard;
      reset = 1'b1;
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
      s_awaddr = 32'd0; s_araddr = 32'd0; s_wdata = 64'd0; s_wstrb = 8'd0; s_wlast = 1'b1;
      s_awsize = 3'd3; s_arsize = 3'd3; s_awcache = 4'd0; s_arcache = 4'd0;
      s_awprot = 3'd0; s_arprot = 3'd0;
      model_reset();

      // reset values and prescaled count
      do_reset();
      check_eq("rst_mtime", dut_mtime, 64'd0);
      check_eq("rst_irqs", {62'd0, int_m_timer, int_m_software}, 64'd0);
      check_eq("rst_valids", {62'd0, s_bvalid, s_rvalid}, 64'd0);
      check_eq("rst_payload", {59'd0, s_bresp, s_rresp, s_rlast}, 64'd0);
      check_eq("rst_rdata", s_rdata, 64'd0);
      repeat (20) step(1'b0);
      check_eq("mtime_20cyc", dut_mtime, 64'd5);

      // timer interrupt rise and fall
      axi_write(32'h0200_4000, 64'h40, 8'hFF, 0, rr);
      guard = 0;
      while (m_mtime != 64'h40 && guard < 1000) begin
         step(1'b0);
         guard++;
      end
      check_eq("reach_40", dut_mtime, 64'h40);
      check_eq("irq_before", {63'd0, int_m_timer}, 64'd0);
      step(1'b0);
      check_eq("irq_rise", {63'd0, int_m_timer}, 64'd1);
      axi_write(32'h0200_4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rr);
      check_eq("irq_fall", {63'd0, int_m_timer}, 64'd0);

      // software interrupt and strobes
      axi_write(32'h0200_0000, 64'h1, 8'h01, 1, rr);
      check_eq("msip_set", {63'd0, int_m_software}, 64'd1);
      axi_read(32'h0200_0000, 0, rd, rr);
      check_eq("msip_rd", rd, 64'h1);
      check_eq("msip_rresp", {62'd0, rr}, 64'd0);
      axi_write(32'h0200_0000, 64'h0, 8'h00, 0, rr);
      check_eq("msip_nostrb", {63'd0, int_m_software}, 64'd1);
      axi_write(32'h0200_4000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 0, rr);
      axi_read(32'h0200_4000, 2, rd, rr);
      check_eq("cmp_hiword", rd, 64'hDEAD_BEEF_FFFF_FFFF);

      // decode errors
      axi_write(32'h0200_1000, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, rr);
      check_eq("dec_bresp1", {62'd0, rr}, 64'd3);
      axi_write(32'h0300_4000, 64'h0, 8'hFF, 0, rr);
      check_eq("dec_bresp2", {62'd0, rr}, 64'd3);
      axi_read(32'h0200_1000, 0, rd, rr);
      check_eq("dec_rdata1", rd, 64'd0);
      check_eq("dec_rresp1", {62'd0, rr}, 64'd3);
      axi_read(32'h0300_4000, 0, rd, rr);
      check_eq("dec_rresp2", {62'd0, rr}, 64'd3);
      axi_read(32'h0200_4000, 0, rd, rr);
      check_eq("dec_cmp_kept", rd, 64'hDEAD_BEEF_FFFF_FFFF);

      // same-cycle read/write of mtimecmp with 10-cycle backpressure
      old_cmp = m_cmp;
      axi_rw(32'h0200_4000, 64'h0000_0000_0001_0000, 8'hFF, 32'h0200_4000, 10, rd);
      check_eq("rw_old_cmp", rd, old_cmp);

      // AW presented alone for 3 cycles before W
      s_awvalid = 1'b1; s_awaddr = 32'h0200_4000; s_wdata = 64'h0000_0000_0002_0000; s_wstrb = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("aw_alone", {62'd0, s_awready, s_wready}, 64'd0);
         step(1'b0);
      end
      s_wvalid = 1'b1;
      #1;
      check_eq("aw_w_accept", {62'd0, s_awready, s_wready}, 64'd3);
      step(1'b1);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
      check_eq("aw_w_bvalid", {63'd0, s_bvalid}, 64'd1);
      step(1'b0);
      s_bready = 1'b0;

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         logic [31:0] wa, ra;
         logic [63:0] wd;
         logic [7:0]  ws;
         int          op;
         op = $urandom_range(0, 2);
         wa = addr_tab[$urandom_range(0, 6)];
         ra = addr_tab[$urandom_range(0, 6)];
         wd = {$urandom, $urandom};
         ws = 8'($urandom);
         if (op == 0) axi_write(wa, wd, ws, $urandom_range(0, 2), rr);
         else if (op == 1) axi_read(ra, $urandom_range(0, 2), rd, rr);
         else axi_rw(wa, wd, ws, ra, $urandom_range(0, 2), rd);
         repeat ($urandom_range(0, 2)) step(1'b0);
      end

      // reset while responses are pending
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      s_awaddr = 32'h0200_0000; s_wdata = 64'h1; s_wstrb = 8'h01; s_araddr = 32'h0200_BFF8;
      step(1'b1);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      check_eq("pre_rst_valids", {62'd0, s_bvalid, s_rvalid}, 64'd3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_abandon", {61'd0, s_bvalid, s_rvalid, s_rlast}, 64'd0);
      reset = 1'b0;
      model_reset();
      s_bready = 1'b1; s_rready = 1'b1;
      repeat (3) begin
         step(1'b0);
         check_eq("no_resp_after_rst", {62'd0, s_bvalid, s_rvalid}, 64'd0);
      end
      s_bready = 1'b0; s_rready = 1'b0;

      // mtime wrap
      axi_write(32'h0200_BFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rr);
      guard = 0;
      while (m_mtime != 64'd0 && guard < 20) begin
         step(1'b0);
         guard++;
      end
      check_eq("mtime_wrap", dut_mtime, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
